request_encoder32: RTL

Round-robin request encoder: the reverse of the processor's 5-to-32 one-hot register decoder. Collects single-cycle request pulses on a 32-bit one-hot/multi-hot vector into a pending set. Emits one 5-bit binary index per accepted transfer over a valid/ready handshake. Used for interrupt/exception source numbering and multi-source writeback arbitration next to the register file.

---
 rtl/encoder_pkg.sv | 18 +
 rtl/rr_pick32.sv | 38 +++
 rtl/request_encoder32.sv | 78 +++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the round-robin request encoder.
//   N      : number of request lines (fixed at 32)
//   IDX_W  : width of an encoded index (log2(N))
//   onehot32(idx) : 32-bit one-hot vector with bit idx set, used as the
//                   pending-clear mask for the granted line
package encoder_pkg;

    localparam int N     = 32;
    localparam int IDX_W = 5;

    function automatic logic [N-1:0] onehot32(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick32.sv
// Combinational round-robin picker over a 32-bit vector.
// Ports:
//   vector [31:0] in  : candidate set
//   ptr    [4:0]  in  : search start position (highest priority index)
//   found         out : at least one bit of vector is set
//   idx    [4:0]  out : first set bit at or above ptr, wrapping 31 -> 0
module rr_pick32
    import encoder_pkg::*;
(
    input  logic [N-1:0]     vector,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;

    // Rotate right by ptr so the search start lands on bit 0. A shift
    // by 32 (ptr == 0) yields zero, leaving the plain vector.
    assign w_rot = (vector >> ptr) | (vector << (6'd32 - {1'b0, ptr}));

    // Lowest set bit wins: scan downward so the last hit is the lowest.
    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_off = i[IDX_W-1:0];
            end
        end
    end

    // Undo the rotation; 5-bit addition wraps modulo 32.
    assign idx = w_off + ptr;

endmodule

// File: rtl/request_encoder32.sv
// Round-robin request encoder. Request pulses accumulate into a pending
// set; one binary index per accepted transfer is emitted over valid/ready.
// Ports:
//   clock            in  : single clock, rising edge
//   reset            in  : synchronous, active-high
//   req_in    [31:0] in  : request pulses, OR-ed into pending
//   enc_valid        out : enc_index holds a granted request
//   enc_ready        in  : consumer accepts on enc_valid && enc_ready
//   enc_index [4:0]  out : granted request index (registered)
//   pending   [31:0] out : registered pending set
//   idle             out : nothing pending and no output held
module request_encoder32 #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req_in,
    output logic             enc_valid,
    input  logic             enc_ready,
    output logic [IDX_W-1:0] enc_index,
    output logic [N-1:0]     pending,
    output logic             idle
);

    import encoder_pkg::*;

    logic [N-1:0]     r_pending;
    logic [IDX_W-1:0] r_ptr;
    logic             r_valid;
    logic [IDX_W-1:0] r_index;

    logic             w_slot_free;
    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic             w_grant;
    logic [N-1:0]     w_clr_mask;

    // Search only the registered pending set; requests never bypass it.
    rr_pick32 u_pick (
        .vector (r_pending),
        .ptr    (r_ptr),
        .found  (w_found),
        .idx    (w_pick)
    );

    assign w_slot_free = !r_valid || enc_ready;
    assign w_grant     = w_slot_free && w_found;
    assign w_clr_mask  = w_grant ? onehot32(w_pick) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
            r_ptr     <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
        end else begin
            // Clear before OR so a same-edge re-request keeps the bit set.
            r_pending <= (r_pending & ~w_clr_mask) | req_in;
            if (w_slot_free) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_index <= w_pick;
                    r_ptr   <= w_pick + 1'b1;
                end else begin
                    // Index deliberately holds its last value.
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign enc_valid = r_valid;
    assign enc_index = r_index;
    assign pending   = r_pending;
    assign idle      = (r_pending == '0) && !r_valid;

endmodule
